// File: rtl/xadac_pkg.sv
// Shared constants and types for the xadac execute-unit arbiter slice.
//   NumExReq      : upper bound on requesters sharing one execute unit; sizes arb_idx_t
//   ArbFifoDepth  : default number of outstanding routed requests
//   ExIdW/ExDataW/ExRegW : xadac_ex_if field widths
//   arb_idx_t     : requester index carried through the route FIFO
//   arb_state_e   : grant lock state
package xadac_pkg;

  localparam int unsigned NumExReq     = 8;
  localparam int unsigned ArbFifoDepth = 4;
  localparam int unsigned ExIdW        = 4;
  localparam int unsigned ExDataW      = 32;
  localparam int unsigned ExRegW       = 5;

  typedef logic [$clog2(NumExReq)-1:0] arb_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  // (idx + 1) mod n, for idx < n
  function automatic arb_idx_t arb_wrap_inc(input arb_idx_t idx, input int unsigned n);
    return (32'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/xadac_ex_if.sv
// Request/response channel between a requester and an execute unit.
//   mst : issues requests (req_*), accepts responses (resp_ready)
//   slv : accepts requests (req_ready), returns responses (resp_*)
interface xadac_ex_if;

  logic                              req_valid;
  logic                              req_ready;
  logic [xadac_pkg::ExIdW-1:0]       req_id;
  logic [xadac_pkg::ExDataW-1:0]     req_imm;
  logic [xadac_pkg::ExDataW-1:0]     req_vs1;
  logic [xadac_pkg::ExDataW-1:0]     req_vs2;
  logic [xadac_pkg::ExDataW-1:0]     req_vs3;
  logic                              resp_valid;
  logic                              resp_ready;
  logic [xadac_pkg::ExDataW-1:0]     resp_vd;
  logic [xadac_pkg::ExRegW-1:0]      resp_rd;
  logic [xadac_pkg::ExIdW-1:0]       resp_id;

  modport mst (
    output req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3, resp_ready,
    input  req_ready, resp_valid, resp_vd, resp_rd, resp_id
  );

  modport slv (
    input  req_valid, req_id, req_imm, req_vs1, req_vs2, req_vs3, resp_ready,
    output req_ready, resp_valid, resp_vd, resp_rd, resp_id
  );

endinterface

// File: rtl/xadac_arb_fifo.sv
// Route FIFO holding the requester index of each issued, not yet answered request.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : enqueue din (ignored when full)
//   pop      : dequeue head (ignored when empty)
//   head     : oldest entry; full/empty status
module xadac_arb_fifo
  import xadac_pkg::*;
#(
  parameter int unsigned Depth = ArbFifoDepth
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  arb_idx_t din,
  output arb_idx_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   cnt_q;
  arb_idx_t        mem_q [Depth];
  logic            push_ok, pop_ok;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/xadac_ex_arbiter.sv
// Round-robin arbiter sharing one in-order execute unit between NumReq requesters.
//   clk, rst   : clock, synchronous active-high reset
//   up[NumReq] : requester-facing slave ports
//   dn         : master port to the shared execute unit
//   stat_grant : per-requester accepted-request counters  (XADAC_ARB_STATS_EN only)
//   stat_full  : cycles with route FIFO full and a request pending (XADAC_ARB_STATS_EN only)
// Optional feature macro: XADAC_ARB_STATS_EN.
// Responses are routed by issue order through a FIFO of grant indices; with the
// FIFO empty a same-cycle response is bypassed to the current grant.
module xadac_ex_arbiter
  import xadac_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned FifoDepth = ArbFifoDepth
) (
  input  logic    clk,
  input  logic    rst,
  xadac_ex_if.slv up [NumReq],
  xadac_ex_if.mst dn
`ifdef XADAC_ARB_STATS_EN
  ,
  output logic [31:0] stat_grant [NumReq],
  output logic [31:0] stat_full
`endif
);

  // Requester fields padded out to NumExReq so arb_idx_t indexes them directly.
  logic [NumExReq-1:0] req_valid_vec;
  logic [NumExReq-1:0] resp_ready_vec;
  logic [ExIdW-1:0]    req_id_arr  [NumExReq];
  logic [ExDataW-1:0]  req_imm_arr [NumExReq];
  logic [ExDataW-1:0]  req_vs1_arr [NumExReq];
  logic [ExDataW-1:0]  req_vs2_arr [NumExReq];
  logic [ExDataW-1:0]  req_vs3_arr [NumExReq];

  arb_state_e state_q, state_d;
  arb_idx_t   lock_idx_q, lock_idx_d;
  arb_idx_t   rr_q;
  arb_idx_t   grant, route, head;
  logic       gvalid, full, empty;
  logic       req_ready_any, resp_valid_any;
  logic       req_hs, resp_hs, route_ok, push, pop;

  for (genvar k = 0; k < NumExReq; k++) begin : g_up
    if (k < NumReq) begin : g_act
      assign req_valid_vec[k]  = up[k].req_valid;
      assign resp_ready_vec[k] = up[k].resp_ready;
      assign req_id_arr[k]     = up[k].req_id;
      assign req_imm_arr[k]    = up[k].req_imm;
      assign req_vs1_arr[k]    = up[k].req_vs1;
      assign req_vs2_arr[k]    = up[k].req_vs2;
      assign req_vs3_arr[k]    = up[k].req_vs3;
      assign up[k].req_ready   = req_ready_any && (grant == arb_idx_t'(k));
      assign up[k].resp_valid  = resp_valid_any && (route == arb_idx_t'(k));
      assign up[k].resp_vd     = dn.resp_vd;
      assign up[k].resp_rd     = dn.resp_rd;
      assign up[k].resp_id     = dn.resp_id;
    end else begin : g_pad
      assign req_valid_vec[k]  = 1'b0;
      assign resp_ready_vec[k] = 1'b0;
      assign req_id_arr[k]     = '0;
      assign req_imm_arr[k]    = '0;
      assign req_vs1_arr[k]    = '0;
      assign req_vs2_arr[k]    = '0;
      assign req_vs3_arr[k]    = '0;
    end
  end

  // Grant: locked requester if it still requests, else first valid from rr_q upward.
  always_comb begin : b_grant
    int unsigned cand;
    grant  = rr_q;
    gvalid = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(rr_q) + i) % NumReq;
      if (!gvalid && req_valid_vec[arb_idx_t'(cand)]) begin
        grant  = arb_idx_t'(cand);
        gvalid = 1'b1;
      end
    end
    if (state_q == ARB_LOCK && req_valid_vec[lock_idx_q]) begin
      grant  = lock_idx_q;
      gvalid = 1'b1;
    end
  end

  assign req_ready_any = !rst && gvalid && !full && dn.req_ready;
  assign req_hs        = req_ready_any;

  assign dn.req_valid  = !rst && gvalid && !full;
  assign dn.req_id     = req_id_arr[grant];
  assign dn.req_imm    = req_imm_arr[grant];
  assign dn.req_vs1    = req_vs1_arr[grant];
  assign dn.req_vs2    = req_vs2_arr[grant];
  assign dn.req_vs3    = req_vs3_arr[grant];

  // A response is only routable if something is queued or being issued this cycle.
  assign route_ok       = !empty || req_hs;
  assign route          = empty ? grant : head;
  assign resp_valid_any = !rst && route_ok && dn.resp_valid;
  assign dn.resp_ready  = !rst && route_ok && resp_ready_vec[route];
  assign resp_hs        = dn.resp_valid && dn.resp_ready;

  // Empty FIFO with both handshakes is the bypass case: nothing enters or leaves.
  assign push = req_hs && !(empty && resp_hs);
  assign pop  = resp_hs && !empty;

  xadac_arb_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (grant),
    .head (head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_d    = ARB_IDLE;
    lock_idx_d = lock_idx_q;
    if (gvalid && !req_hs) begin
      state_d    = ARB_LOCK;
      lock_idx_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      if (req_hs) rr_q <= arb_wrap_inc(grant, NumReq);
    end
  end

`ifdef XADAC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NumReq; k++) stat_grant[k] <= '0;
      stat_full <= '0;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (req_hs && grant == arb_idx_t'(k) && stat_grant[k] != '1)
          stat_grant[k] <= stat_grant[k] + 1'b1;
      end
      if (gvalid && full && stat_full != '1) stat_full <= stat_full + 1'b1;
    end
  end
`endif

  a_resp_orphan: assert property (@(posedge clk) disable iff (rst)
    !(dn.resp_valid && !route_ok));

endmodule

// File: tb/tb_xadac_ex_arbiter.sv
module tb_xadac_ex_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xadac_ex_if up_if [2] ();
  xadac_ex_if dn_if ();

`ifdef XADAC_ARB_STATS_EN
  logic [31:0] stat_grant [2];
  logic [31:0] stat_full;
`endif

  xadac_ex_arbiter #(.NumReq(2), .FifoDepth(4)) dut (
    .clk (clk),
    .rst (rst),
    .up  (up_if),
    .dn  (dn_if)
`ifdef XADAC_ARB_STATS_EN
    ,
    .stat_grant(stat_grant),
    .stat_full (stat_full)
`endif
  );

  int checks = 0;
  int failures = 0;

  localparam logic [3:0]  IdA  = 4'hA;
  localparam logic [3:0]  IdB  = 4'h5;
  localparam logic [31:0] Vs0  = 32'h1111_0000;
  localparam logic [31:0] Vs1  = 32'h2222_0000;
  localparam logic [31:0] Imm0 = 32'h0000_0100;
  localparam logic [31:0] Imm1 = 32'h0000_0200;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // v0 v1 drdy rv rr0 rr1 | expected dv r0 r1 rv0 rv1 drr, grant g
  typedef struct packed {
    logic v0, v1, drdy, rv, rr0, rr1;
    logic dv, r0, r1, rv0, rv1, drr;
    logic g;
  } vec_t;

  vec_t tbl [13];

  task automatic drive(input logic v0, v1, drdy, rv, rr0, rr1);
    up_if[0].req_valid  = v0;
    up_if[1].req_valid  = v1;
    dn_if.req_ready     = drdy;
    dn_if.resp_valid    = rv;
    up_if[0].resp_ready = rr0;
    up_if[1].resp_ready = rr1;
  endtask

  task automatic chk_ctl(input string name, input logic [5:0] exp);
    chk(name, {dn_if.req_valid, up_if[0].req_ready, up_if[1].req_ready,
               up_if[0].resp_valid, up_if[1].resp_valid, dn_if.resp_ready}, 128'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Latency-2 unit model state
  int unsigned u_t [$];
  logic [3:0]  u_id [$];
  int          exp_own [$];
  logic [3:0]  exp_id [$];

  initial begin
    int rem0, rem1, occ, fullcyc, done, own, eo, cnt0, cnt1;
    logic [3:0] nid0, nid1;
    logic hs, rhs;

    tbl[0]  = '{1,1,1,1,1,1, 1,1,0,1,0,1, 0};
    tbl[1]  = '{1,1,1,1,1,1, 1,0,1,0,1,1, 1};
    tbl[2]  = '{1,1,1,1,1,1, 1,1,0,1,0,1, 0};
    tbl[3]  = '{1,1,1,1,1,1, 1,0,1,0,1,1, 1};
    tbl[4]  = '{0,1,0,0,0,0, 1,0,0,0,0,0, 1};
    tbl[5]  = '{1,1,0,0,0,0, 1,0,0,0,0,0, 1};
    tbl[6]  = '{1,1,0,0,0,0, 1,0,0,0,0,0, 1};
    tbl[7]  = '{1,1,1,1,1,1, 1,0,1,0,1,1, 1};
    tbl[8]  = '{1,1,1,1,1,1, 1,1,0,1,0,1, 0};
    tbl[9]  = '{1,0,1,1,0,0, 1,1,0,1,0,0, 0};
    tbl[10] = '{0,1,1,1,1,1, 1,0,1,1,0,1, 1};
    tbl[11] = '{0,0,1,1,1,1, 0,0,0,0,1,1, 0};
    tbl[12] = '{0,0,1,0,0,0, 0,0,0,0,0,0, 0};

    up_if[0].req_id = IdA; up_if[0].req_imm = Imm0; up_if[0].req_vs1 = Vs0;
    up_if[0].req_vs2 = '0; up_if[0].req_vs3 = '0;
    up_if[1].req_id = IdB; up_if[1].req_imm = Imm1; up_if[1].req_vs1 = Vs1;
    up_if[1].req_vs2 = '0; up_if[1].req_vs3 = '0;
    dn_if.resp_vd = '0; dn_if.resp_rd = 5'd3; dn_if.resp_id = '0;

    // Reset with active inputs: everything must stay quiet.
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    #2;
    chk_ctl("reset_outputs", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Table: alternation, lock under back-pressure, response routing via FIFO head.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].v1, tbl[i].drdy, tbl[i].rv, tbl[i].rr0, tbl[i].rr1);
      dn_if.resp_vd = 32'hC0DE_0000 + 32'(i);
      dn_if.resp_id = 4'(i);
      #2;
      chk_ctl($sformatf("tbl%0d_ctl", i),
              {tbl[i].dv, tbl[i].r0, tbl[i].r1, tbl[i].rv0, tbl[i].rv1, tbl[i].drr});
      if (tbl[i].dv)
        chk($sformatf("tbl%0d_fwd", i), {dn_if.req_id, dn_if.req_vs1, dn_if.req_imm},
            tbl[i].g ? {IdB, Vs1, Imm1} : {IdA, Vs0, Imm0});
      if (tbl[i].rv0 || tbl[i].rv1)
        chk($sformatf("tbl%0d_resp", i),
            tbl[i].rv1 ? {up_if[1].resp_vd, up_if[1].resp_id} : {up_if[0].resp_vd, up_if[0].resp_id},
            {32'hC0DE_0000 + 32'(i), 4'(i)});
    end

    // Latency-2 unit, responses held back: FIFO fills, 5th request blocked.
    do_reset();
    rem0 = 3; rem1 = 2; occ = 0; fullcyc = 0; done = 0;
    nid0 = 4'h0; nid1 = 4'h8;
    for (int cyc = 0; cyc < 40 && done < 5; cyc++) begin
      @(negedge clk);
      up_if[0].req_valid  = rem0 > 0;
      up_if[1].req_valid  = rem1 > 0;
      up_if[0].req_id     = nid0;
      up_if[1].req_id     = nid1;
      up_if[0].resp_ready = cyc >= 8;
      up_if[1].resp_ready = cyc >= 8;
      dn_if.req_ready     = 1'b1;
      dn_if.resp_valid    = (u_id.size() > 0) && (cyc >= int'(u_t[0]) + 2);
      dn_if.resp_id       = (u_id.size() > 0) ? u_id[0] : 4'h0;
      dn_if.resp_vd       = {28'h0, dn_if.resp_id};
      #2;
      chk($sformatf("lat_c%0d_req_valid", cyc), 128'(dn_if.req_valid),
          128'(((rem0 > 0) || (rem1 > 0)) && (occ < 4)));
      if (((rem0 > 0) || (rem1 > 0)) && occ >= 4) fullcyc++;
      hs = dn_if.req_valid && dn_if.req_ready;
      own = 0;
      if (hs) begin
        own = up_if[1].req_ready ? 1 : 0;
        chk("lat_one_ready", 128'(up_if[0].req_ready ^ up_if[1].req_ready), 128'(1));
        chk("lat_req_id", 128'(dn_if.req_id), 128'(own == 1 ? nid1 : nid0));
        exp_own.push_back(own);
        exp_id.push_back(own == 1 ? nid1 : nid0);
      end
      rhs = dn_if.resp_valid && dn_if.resp_ready;
      if (dn_if.resp_valid && exp_own.size() > 0) begin
        eo = exp_own[0];
        chk("lat_resp_route", 128'({up_if[1].resp_valid, up_if[0].resp_valid}),
            128'(eo == 1 ? 2'b10 : 2'b01));
        chk("lat_resp_id", 128'(eo == 1 ? up_if[1].resp_id : up_if[0].resp_id), 128'(exp_id[0]));
        chk("lat_dn_resp_ready", 128'(dn_if.resp_ready), 128'(cyc >= 8));
      end
      @(posedge clk);
      #1;
      if (hs) begin
        u_t.push_back(cyc);
        u_id.push_back(own == 1 ? nid1 : nid0);
        if (own == 1) begin rem1--; nid1++; end
        else begin rem0--; nid0++; end
        occ++;
      end
      if (rhs && exp_own.size() > 0) begin
        void'(u_t.pop_front()); void'(u_id.pop_front());
        void'(exp_own.pop_front()); void'(exp_id.pop_front());
        occ--;
        done++;
      end
    end
    chk("lat_all_responses", 128'(done), 128'(5));
`ifdef XADAC_ARB_STATS_EN
    chk("lat_stat_full", 128'(stat_full), 128'(fullcyc));
    chk("lat_stat_full_nonzero", 128'(stat_full != 0), 128'(1));
`endif

    // Reset with 3 queued entries discards routing state and rr pointer.
    @(negedge clk);
    dn_if.resp_valid = 1'b0;
    up_if[0].req_id = IdA; up_if[1].req_id = IdB;
    do_reset();
    @(negedge clk); drive(1, 0, 1, 0, 0, 0);
    @(negedge clk); drive(0, 1, 1, 0, 0, 0);
    @(negedge clk); drive(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 1);
    #2;
    chk_ctl("midrst_outputs", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    #2;
    chk("midrst_rr0_grant", {dn_if.req_valid, dn_if.req_id}, {1'b1, IdA});
`ifdef XADAC_ARB_STATS_EN
    chk("midrst_stats_zero", {stat_grant[0], stat_grant[1], stat_full}, 128'(0));
`endif
    @(negedge clk);
    drive(0, 1, 1, 1, 0, 1);
    #2;
    chk_ctl("midrst_bypass_route", 6'b101011);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);

    // Zero-latency unit: 10 requests from requester 0, 7 from requester 1.
    do_reset();
    rem0 = 10; rem1 = 7; cnt0 = 0; cnt1 = 0;
    for (int cyc = 0; cyc < 60 && (rem0 > 0 || rem1 > 0); cyc++) begin
      @(negedge clk);
      up_if[0].req_valid  = rem0 > 0;
      up_if[1].req_valid  = rem1 > 0;
      up_if[0].resp_ready = 1'b1;
      up_if[1].resp_ready = 1'b1;
      dn_if.req_ready     = 1'b1;
      #1;
      dn_if.resp_valid    = dn_if.req_valid;
      dn_if.resp_id       = dn_if.req_id;
      #1;
      hs = dn_if.req_valid && dn_if.req_ready;
      if (hs) begin
        own = up_if[1].req_ready ? 1 : 0;
        chk("zl_resp_to_issuer", 128'({up_if[1].resp_valid, up_if[0].resp_valid}),
            128'(own == 1 ? 2'b10 : 2'b01));
      end
      @(posedge clk);
      #1;
      if (hs) begin
        if (own == 1) begin rem1--; cnt1++; end
        else begin rem0--; cnt0++; end
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("zl_grants", {cnt0, cnt1}, {32'd10, 32'd7});
`ifdef XADAC_ARB_STATS_EN
    chk("zl_stat_grant", {stat_grant[1], stat_grant[0]}, {32'd7, 32'd10});
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xadac_ex_arbiter.md
XADAC_EX_ARBITER -- requirements
Module: xadac_ex_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one execute unit (2..8).
REQ-002 SHALL have parameter FifoDepth, default 4, number of outstanding routed requests (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port up  xadac_ex_if.slv  array[NumReq]  requester-facing ports, full xadac_ex_if field set.
REQ-006 SHALL have port dn  xadac_ex_if.mst  1  port to the shared execute unit (e.g. xadac_vmacc_unit).
REQ-007 SHALL have port stat_grant  output  NumReq x 32  per-requester accepted-request counters (present only under XADAC_ARB_STATS_EN).
REQ-008 SHALL have port stat_full  output  32  cycles with route FIFO full and a pending request (present only under XADAC_ARB_STATS_EN).

Function
REQ-009 SHALL select one requester per cycle round-robin among asserted up[k].req_valid, searching from pointer rr_q upward with wrap.
REQ-010 SHALL hold the grant (lock) while the granted requester has req_valid=1 and no dn handshake has occurred.
REQ-011 SHALL forward the granted requester's req_id, req_imm, req_vs1/2/3 unchanged to dn; dn.req_valid = granted req_valid AND NOT fifo_full.
REQ-012 SHALL drive up[grant].req_ready = dn.req_ready AND NOT fifo_full; all other up[k].req_ready = 0.
REQ-013 SHALL on each dn request handshake set rr_q to (grant+1) mod NumReq.
REQ-014 SHALL route responses in order: route index = FIFO head if FIFO non-empty, else current grant (same-cycle bypass for the zero-latency unit).
REQ-015 SHALL drive up[route].resp_valid = dn.resp_valid and up[route].resp_vd/resp_rd/resp_id from dn; other up[k].resp_valid = 0; dn.resp_ready = up[route].resp_ready.
REQ-016 SHALL push grant index on a request handshake and pop on a response handshake; with FIFO empty and both handshakes in the same cycle, neither push nor pop occurs.
REQ-017 SHALL allow simultaneous push and pop with FIFO non-empty (occupancy unchanged); no push when full, even with a same-cycle pop.
REQ-018 SHALL treat dn.resp_valid with an empty FIFO and no same-cycle request handshake as illegal: response dropped (dn.resp_ready=0), simulation assertion fires.
REQ-019 SHALL require an in-order execute unit; response IDs are not used for routing.
REQ-020 SHALL keep dn.req_valid = 0 when no requester is valid; data fields then are don't-care.

Reset
REQ-021 SHALL while rst=1 force rr_q=0, FIFO empty, every up[k].req_ready/resp_valid=0, dn.req_valid=0, dn.resp_ready=0, statistics counters 0.
REQ-022 SHALL on reset mid-operation discard all in-flight routing entries; the first cycle after reset behaves as power-up.

Configuration
REQ-023 SHALL compile statistics counters only when XADAC_ARB_STATS_EN is defined: stat_grant[k] increments per handshake of requester k, stat_full per full-and-pending cycle, both saturating at 2^32-1.
REQ-024 SHALL without XADAC_ARB_STATS_EN omit stat_* ports and counter logic; arbitration behaviour identical.

Structure
REQ-025 SHALL place constants NumExReq and ArbFifoDepth and typedef arb_idx_t (logic [$clog2(NumExReq)-1:0]) in xadac_pkg.
REQ-026 SHALL implement the route FIFO as sub-module xadac_arb_fifo (width arb_idx_t, depth FifoDepth, push/pop/full/empty/head).

Verification
REQ-027 Both requesters valid every cycle, dn ready, zero-latency unit -> grants alternate 0,1,0,1; FIFO stays empty; each response returns to its issuer.
REQ-028 Requester 1 valid, dn.req_ready=0 for 3 cycles while requester 0 asserts valid -> grant stays on 1, fields stable, up[0].req_ready=0 until handshake.
REQ-029 Unit with 2-cycle response latency, 5 back-to-back requests, FifoDepth=4 -> 5th blocked while full, stat_full increments, responses in issue order.
REQ-030 Request handshake alongside a pending response with up[route].resp_ready=0 -> FIFO pushes only; occupancy +1; dn.resp_ready=0.
REQ-031 rst asserted with 3 entries queued -> next cycle FIFO empty, rr_q=0, all valids 0, counters 0.
REQ-032 With XADAC_ARB_STATS_EN, 10 grants to requester 0 and 7 to requester 1 -> stat_grant = {7,10}; without macro, stat_* absent and same traffic passes.
